pipe_id_ex_elastic: RTL and testbench

//  ID->EX pipeline register, elastic: valid/ready handshake on both sides, optional skid entry,

---
 rtl/pipe_id_ex_elastic.sv | 191 +++++++++++++++++++
 tb/tb_pipe_id_ex_elastic.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_id_ex_elastic.sv
// Elastic ID->EX pipeline register: valid/ready on both sides, optional skid entry,
// synchronous flush, and load-use hazard detection that inserts exactly one bubble.
module pipe_id_ex_elastic #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int OPW      = 4,
    parameter int SKID     = 1,
    parameter int LOAD_USE = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   ALUOP_IN,
    input  logic             ALUSRC_IN,
    input  logic             REGWRITE_IN,
    input  logic             MEMTOREG_IN,
    input  logic             MEMWRITE_IN,
    input  logic             MEMREAD_IN,
    input  logic [AW-1:0]    ARS1_IN,
    input  logic [AW-1:0]    ARS2_IN,
    input  logic [AW-1:0]    ARD_IN,
    input  logic [WIDTH-1:0] RS1_IN,
    input  logic [WIDTH-1:0] RS2_IN,
    input  logic [WIDTH-1:0] IMMEDIATE_IN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   ALUOP_OUT,
    output logic             ALUSRC_OUT,
    output logic             REGWRITE_OUT,
    output logic             MEMTOREG_OUT,
    output logic             MEMWRITE_OUT,
    output logic             MEMREAD_OUT,
    output logic [AW-1:0]    ARS1_OUT,
    output logic [AW-1:0]    ARS2_OUT,
    output logic [AW-1:0]    ARD_OUT,
    output logic [WIDTH-1:0] RS1_OUT,
    output logic [WIDTH-1:0] RS2_OUT,
    output logic [WIDTH-1:0] IMMEDIATE_OUT,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam bit USE_SKID = (SKID != 0);
    localparam bit USE_LU   = (LOAD_USE != 0);

    typedef struct packed {
        logic [OPW-1:0]   aluop;
        logic             alusrc;
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic             memread;
        logic [AW-1:0]    ars1;
        logic [AW-1:0]    ars2;
        logic [AW-1:0]    ard;
        logic [WIDTH-1:0] rs1;
        logic [WIDTH-1:0] rs2;
        logic [WIDTH-1:0] imm;
    } entry_t;

    // An empty main slot must present inert control bits; operands are left untouched.
    function automatic entry_t clear_ctrl(input entry_t e);
        entry_t r;
        r          = e;
        r.aluop    = '0;
        r.alusrc   = 1'b0;
        r.regwrite = 1'b0;
        r.memtoreg = 1'b0;
        r.memwrite = 1'b0;
        r.memread  = 1'b0;
        return r;
    endfunction

    entry_t           in_e;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           young;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             young_valid;
    logic             hazard;
    logic             room;
    logic             in_xfer;
    logic             out_xfer;
    logic             count_en;

    assign in_e = '{aluop: ALUOP_IN, alusrc: ALUSRC_IN, regwrite: REGWRITE_IN,
                    memtoreg: MEMTOREG_IN, memwrite: MEMWRITE_IN, memread: MEMREAD_IN,
                    ars1: ARS1_IN, ars2: ARS2_IN, ard: ARD_IN,
                    rs1: RS1_IN, rs2: RS2_IN, imm: IMMEDIATE_IN};

    // The youngest held instruction is the one a new ID instruction could depend on.
    always_comb begin
        young       = skid_valid_q ? skid_q : main_q;
        young_valid = skid_valid_q | main_valid_q;
        hazard      = 1'b0;
        if (USE_LU) begin
            hazard = young_valid & young.memread & (young.ard != '0) & in_valid &
                     ((ARS1_IN == young.ard) | (ARS2_IN == young.ard));
        end
    end

    always_comb begin
        room = 1'b0;
        if (USE_SKID) begin
            room = ~skid_valid_q;
        end else begin
            room = ~main_valid_q | out_ready;
        end
    end

    assign in_ready = ~rst & ~flush & ~hazard & room;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid_q & out_ready;
    // A bubble is counted once, on the cycle the load itself leaves the main slot.
    assign count_en = hazard & ~flush & ~skid_valid_q & out_xfer;

    // NOTE: every next-state value gets a default first so no path can infer a latch.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d       = clear_ctrl(main_q);
        end else if (out_xfer) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_d = in_e;
            end else begin
                main_valid_d = 1'b0;
                main_d       = clear_ctrl(main_q);
            end
        end else if (in_xfer) begin
            if (!main_valid_q) begin
                main_d       = in_e;
                main_valid_d = 1'b1;
            end else if (USE_SKID) begin
                skid_d       = in_e;
                skid_valid_d = 1'b1;
            end
        end

        if (count_en && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: the skid payload is reset along with main so no stale bits can ever surface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all update together.
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid     = main_valid_q;
    assign ALUOP_OUT     = main_q.aluop;
    assign ALUSRC_OUT    = main_q.alusrc;
    assign REGWRITE_OUT  = main_q.regwrite;
    assign MEMTOREG_OUT  = main_q.memtoreg;
    assign MEMWRITE_OUT  = main_q.memwrite;
    assign MEMREAD_OUT   = main_q.memread;
    assign ARS1_OUT      = main_q.ars1;
    assign ARS2_OUT      = main_q.ars2;
    assign ARD_OUT       = main_q.ard;
    assign RS1_OUT       = main_q.rs1;
    assign RS2_OUT       = main_q.rs2;
    assign IMMEDIATE_OUT = main_q.imm;
    assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_id_ex_elastic.sv
// Bench for pipe_id_ex_elastic: a SKID=1 and a SKID=0 instance, each exercised in turn
// against a queue-level model of the stage, plus directed scenario checks.
module tb_pipe_id_ex_elastic;

    localparam int WIDTH  = 32;
    localparam int AW     = 5;
    localparam int OPW    = 4;
    localparam int CNTW_A = 16;
    localparam int CNTW_B = 3;

    typedef struct packed {
        logic [OPW-1:0]   aluop;
        logic             alusrc;
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic             memread;
        logic [AW-1:0]    ars1;
        logic [AW-1:0]    ars2;
        logic [AW-1:0]    ard;
        logic [WIDTH-1:0] rs1;
        logic [WIDTH-1:0] rs2;
        logic [WIDTH-1:0] imm;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    entry_t in_e;
    logic flush_a, in_valid_a, out_ready_a, in_ready_a, out_valid_a;
    logic flush_b, in_valid_b, out_ready_b, in_ready_b, out_valid_b;
    logic [OPW-1:0] aluop_a, aluop_b;
    logic alusrc_a, regwrite_a, memtoreg_a, memwrite_a, memread_a;
    logic alusrc_b, regwrite_b, memtoreg_b, memwrite_b, memread_b;
    logic [AW-1:0] ars1_a, ars2_a, ard_a, ars1_b, ars2_b, ard_b;
    logic [WIDTH-1:0] rs1_a, rs2_a, imm_a, rs1_b, rs2_b, imm_b;
    logic [CNTW_A-1:0] bcnt_a;
    logic [CNTW_B-1:0] bcnt_b;
    entry_t obs_a, obs_b;

    assign obs_a = {aluop_a, alusrc_a, regwrite_a, memtoreg_a, memwrite_a, memread_a,
                    ars1_a, ars2_a, ard_a, rs1_a, rs2_a, imm_a};
    assign obs_b = {aluop_b, alusrc_b, regwrite_b, memtoreg_b, memwrite_b, memread_b,
                    ars1_b, ars2_b, ard_b, rs1_b, rs2_b, imm_b};

    pipe_id_ex_elastic #(.WIDTH(WIDTH), .AW(AW), .OPW(OPW), .SKID(1), .LOAD_USE(1),
                         .CNT_W(CNTW_A)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .ALUOP_IN(in_e.aluop), .ALUSRC_IN(in_e.alusrc), .REGWRITE_IN(in_e.regwrite),
        .MEMTOREG_IN(in_e.memtoreg), .MEMWRITE_IN(in_e.memwrite), .MEMREAD_IN(in_e.memread),
        .ARS1_IN(in_e.ars1), .ARS2_IN(in_e.ars2), .ARD_IN(in_e.ard),
        .RS1_IN(in_e.rs1), .RS2_IN(in_e.rs2), .IMMEDIATE_IN(in_e.imm),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .ALUOP_OUT(aluop_a), .ALUSRC_OUT(alusrc_a), .REGWRITE_OUT(regwrite_a),
        .MEMTOREG_OUT(memtoreg_a), .MEMWRITE_OUT(memwrite_a), .MEMREAD_OUT(memread_a),
        .ARS1_OUT(ars1_a), .ARS2_OUT(ars2_a), .ARD_OUT(ard_a),
        .RS1_OUT(rs1_a), .RS2_OUT(rs2_a), .IMMEDIATE_OUT(imm_a), .bubble_cnt(bcnt_a)
    );

    pipe_id_ex_elastic #(.WIDTH(WIDTH), .AW(AW), .OPW(OPW), .SKID(0), .LOAD_USE(1),
                         .CNT_W(CNTW_B)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .ALUOP_IN(in_e.aluop), .ALUSRC_IN(in_e.alusrc), .REGWRITE_IN(in_e.regwrite),
        .MEMTOREG_IN(in_e.memtoreg), .MEMWRITE_IN(in_e.memwrite), .MEMREAD_IN(in_e.memread),
        .ARS1_IN(in_e.ars1), .ARS2_IN(in_e.ars2), .ARD_IN(in_e.ard),
        .RS1_IN(in_e.rs1), .RS2_IN(in_e.rs2), .IMMEDIATE_IN(in_e.imm),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .ALUOP_OUT(aluop_b), .ALUSRC_OUT(alusrc_b), .REGWRITE_OUT(regwrite_b),
        .MEMTOREG_OUT(memtoreg_b), .MEMWRITE_OUT(memwrite_b), .MEMREAD_OUT(memread_b),
        .ARS1_OUT(ars1_b), .ARS2_OUT(ars2_b), .ARD_OUT(ard_b),
        .RS1_OUT(rs1_b), .RS2_OUT(rs2_b), .IMMEDIATE_OUT(imm_b), .bubble_cnt(bcnt_b)
    );

    int checks = 0;
    int errors = 0;
    int cur;               // 0: SKID=1 instance, 1: SKID=0 instance

    // Drive state for the active instance.
    logic d_flush, d_valid, d_ready;

    // Reference model: FIFO of held instructions, front = the EX-visible entry.
    entry_t mq [2];
    int     mn;
    entry_t last_main;
    int     mcnt;
    logic   m_in_x, m_out_x;

    // Observations taken at the falling edge.
    logic        o_valid, o_ir;
    entry_t      o_e;
    logic [15:0] o_cnt;

    function automatic int cap();
        return (cur == 0) ? 2 : 1;
    endfunction

    function automatic int sat();
        return (cur == 0) ? 65535 : 7;
    endfunction

    function automatic entry_t zero_ctrl(input entry_t e);
        entry_t r;
        r = e;
        r.aluop = '0; r.alusrc = 1'b0; r.regwrite = 1'b0;
        r.memtoreg = 1'b0; r.memwrite = 1'b0; r.memread = 1'b0;
        return r;
    endfunction

    function automatic entry_t rand_alu(input logic [WIDTH-1:0] tag);
        entry_t e;
        e.aluop    = OPW'($urandom);
        e.alusrc   = 1'($urandom);
        e.regwrite = 1'b1;
        e.memtoreg = 1'b0;
        e.memwrite = 1'($urandom);
        e.memread  = 1'b0;
        e.ars1     = AW'($urandom);
        e.ars2     = AW'($urandom);
        e.ard      = AW'($urandom_range(1, 31));
        e.rs1      = $urandom;
        e.rs2      = $urandom;
        e.imm      = tag;
        return e;
    endfunction

    task automatic drive(input logic f, input logic v, input logic r, input entry_t e);
        d_flush = f; d_valid = v; d_ready = r; in_e = e;
        flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0;
        flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
        if (cur == 0) begin
            flush_a = f; in_valid_a = v; out_ready_a = r;
        end else begin
            flush_b = f; in_valid_b = v; out_ready_b = r;
        end
    endtask

    task automatic sample_obs();
        if (cur == 0) begin
            o_valid = out_valid_a; o_ir = in_ready_a; o_e = obs_a; o_cnt = 16'(bcnt_a);
        end else begin
            o_valid = out_valid_b; o_ir = in_ready_b; o_e = obs_b; o_cnt = 16'(bcnt_b);
        end
    endtask

    task automatic model_clear();
        mn = 0; mcnt = 0; last_main = '0;
    endtask

    // One clock: compare against the model before the edge, then advance the model.
    task automatic cycle();
        entry_t exp_e, y;
        logic   exp_v, exp_ir, hz;
        @(negedge clk);
        sample_obs();
        exp_v = (mn > 0);
        exp_e = (mn > 0) ? mq[0] : zero_ctrl(last_main);
        hz = 1'b0;
        if (mn > 0) begin
            y  = mq[mn-1];
            hz = d_valid && y.memread && (y.ard != '0) &&
                 ((in_e.ars1 == y.ard) || (in_e.ars2 == y.ard));
        end
        exp_ir = !d_flush && !hz && ((cap() == 2) ? (mn < 2) : ((mn == 0) || d_ready));

        checks++;
        if (o_valid !== exp_v) begin
            errors++; $display("FAIL out_valid inst=%0d t=%0t got %b exp %b", cur, $time, o_valid, exp_v);
        end
        checks++;
        if (o_ir !== exp_ir) begin
            errors++; $display("FAIL in_ready inst=%0d t=%0t got %b exp %b", cur, $time, o_ir, exp_ir);
        end
        checks++;
        if (o_e !== exp_e) begin
            errors++; $display("FAIL out_fields inst=%0d t=%0t got %h exp %h", cur, $time, o_e, exp_e);
        end
        checks++;
        if (o_cnt !== 16'(mcnt)) begin
            errors++; $display("FAIL bubble_cnt inst=%0d t=%0t got %0d exp %0d", cur, $time, o_cnt, mcnt);
        end

        m_in_x  = d_valid && exp_ir;
        m_out_x = (mn > 0) && d_ready;
        if (m_out_x && hz && !d_flush && (mn == 1) && (mcnt < sat())) mcnt++;
        if (m_out_x) begin
            mq[0] = mq[1];
            mn--;
        end
        if (d_flush) mn = 0;
        else if (m_in_x) begin
            mq[mn] = in_e;
            mn++;
        end
        if (mn > 0) last_main = mq[0];
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        drive(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, rand_alu(32'h1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        sample_obs();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", o_valid); end
        checks++;
        if (o_ir !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", o_ir); end
        checks++;
        if (o_e !== '0) begin errors++; $display("FAIL rst_fields got %h exp 0", o_e); end
        checks++;
        if (o_cnt !== 16'd0) begin errors++; $display("FAIL rst_bubble_cnt got %0d exp 0", o_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_streaming();
        int nin, nout, acc_cyc;
        int out_at [8];
        reset_all();
        nin = 0; nout = 0; acc_cyc = 0;
        for (int k = 0; k < 14; k++) begin
            drive(1'b0, nin < 8, 1'b1, rand_alu(32'(nin)));
            cycle();
            if (m_in_x) begin
                nin++;
                acc_cyc = k + 1;
            end
            if (o_valid && nout < 8) begin
                checks++;
                if (o_e.imm !== 32'(nout)) begin
                    errors++; $display("FAIL stream_order got %0d exp %0d", o_e.imm, nout);
                end
                out_at[nout] = k;
                nout++;
            end
        end
        checks++;
        if (acc_cyc !== 8) begin errors++; $display("FAIL stream_accept_cycles got %0d exp 8", acc_cyc); end
        checks++;
        if (nout !== 8) begin errors++; $display("FAIL stream_out_count got %0d exp 8", nout); end
        else begin
            checks++;
            if (out_at[0] !== 1 || out_at[7] !== 8) begin
                errors++; $display("FAIL stream_latency got first %0d last %0d exp 1 and 8", out_at[0], out_at[7]);
            end
        end
        checks++;
        if (o_cnt !== 16'd0) begin errors++; $display("FAIL stream_bubble_cnt got %0d exp 0", o_cnt); end
    endtask

    task automatic test_backpressure();
        int nin, nout;
        reset_all();
        nin = 0; nout = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, rand_alu(32'(nin)));
            cycle();
            if (m_in_x) nin++;
        end
        checks++;
        if (nin !== cap()) begin errors++; $display("FAIL bp_accepted got %0d exp %0d", nin, cap()); end
        checks++;
        if (o_ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", o_ir); end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b1, rand_alu(32'hff));
            cycle();
            if (o_valid) begin
                checks++;
                if (o_e.imm !== 32'(nout)) begin
                    errors++; $display("FAIL bp_drain_order got %0d exp %0d", o_e.imm, nout);
                end
                nout++;
            end
        end
        checks++;
        if (nout !== cap()) begin errors++; $display("FAIL bp_drained got %0d exp %0d", nout, cap()); end
    endtask

    task automatic test_load_use(input logic [AW-1:0] ld_rd, input int hold,
                                 input int exp_gap, input int exp_cnt);
        entry_t lw, add;
        int last_lw, first_add;
        logic add_sent;
        reset_all();
        lw = rand_alu(32'h100);
        lw.memread = 1'b1; lw.memtoreg = 1'b1; lw.memwrite = 1'b0; lw.ard = ld_rd;
        add = rand_alu(32'h200);
        add.ars1 = ld_rd; add.ars2 = 5'd7; add.ard = 5'd6;
        drive(1'b0, 1'b1, 1'b1, lw);
        cycle();
        last_lw = -1; first_add = -1; add_sent = 1'b0;
        for (int k = 0; k < 20 && first_add < 0; k++) begin
            drive(1'b0, !add_sent, k >= hold, add);
            cycle();
            if (m_in_x) add_sent = 1'b1;
            if (o_valid && o_e.imm == 32'h100) last_lw = k;
            if (o_valid && o_e.imm == 32'h200) first_add = k;
        end
        checks++;
        if (last_lw < 0 || first_add < 0) begin
            errors++; $display("FAIL lu_seen rd=%0d got lw %0d add %0d exp both >=0", ld_rd, last_lw, first_add);
        end else begin
            checks++;
            if (first_add - last_lw - 1 !== exp_gap) begin
                errors++; $display("FAIL lu_gap rd=%0d hold=%0d got %0d exp %0d", ld_rd, hold,
                                   first_add - last_lw - 1, exp_gap);
            end
        end
        checks++;
        if (o_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL lu_bubble_cnt rd=%0d hold=%0d got %0d exp %0d", ld_rd, hold, o_cnt, exp_cnt);
        end
    endtask

    task automatic test_saturation();
        entry_t lw, add;
        int pairs, exp_cnt;
        logic ph;
        reset_all();
        lw = rand_alu(32'h300);
        lw.memread = 1'b1; lw.memwrite = 1'b0; lw.ard = 5'd5;
        add = rand_alu(32'h301);
        add.ars1 = 5'd5; add.ard = 5'd6;
        pairs = 0; ph = 1'b0;
        for (int k = 0; k < 120 && pairs < 10; k++) begin
            drive(1'b0, 1'b1, 1'b1, ph ? add : lw);
            cycle();
            if (m_in_x) begin
                if (ph) pairs++;
                ph = !ph;
            end
        end
        drive(1'b0, 1'b0, 1'b1, add);
        cycle();
        cycle();
        exp_cnt = (10 < sat()) ? 10 : sat();
        checks++;
        if (pairs !== 10) begin errors++; $display("FAIL sat_pairs got %0d exp 10", pairs); end
        checks++;
        if (o_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL sat_bubble_cnt got %0d exp %0d", o_cnt, exp_cnt);
        end
    endtask

    task automatic test_flush();
        logic [OPW+4:0] ctrl;
        reset_all();
        for (int k = 0; k < cap(); k++) begin
            drive(1'b0, 1'b1, 1'b0, rand_alu(32'(k)));
            cycle();
        end
        drive(1'b1, 1'b1, 1'b0, rand_alu(32'h50));
        cycle();
        checks++;
        if (o_ir !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", o_ir); end
        checks++;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL flush_prev_valid got %b exp 1", o_valid); end
        drive(1'b0, 1'b1, 1'b0, rand_alu(32'h60));
        cycle();
        ctrl = {o_e.aluop, o_e.alusrc, o_e.regwrite, o_e.memtoreg, o_e.memwrite, o_e.memread};
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", o_valid); end
        checks++;
        if (ctrl !== '0) begin errors++; $display("FAIL flush_ctrl got %h exp 0", ctrl); end
        checks++;
        if (o_ir !== 1'b1) begin errors++; $display("FAIL flush_recover got %b exp 1", o_ir); end
        drive(1'b0, 1'b0, 1'b1, rand_alu(32'h61));
        cycle();
        cycle();
    endtask

    task automatic test_async_reset();
        reset_all();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, rand_alu(32'(k)));
            cycle();
        end
        #2;
        rst = 1'b1;
        #1;
        sample_obs();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b exp 0", o_valid); end
        checks++;
        if (o_e !== '0) begin errors++; $display("FAIL arst_fields got %h exp 0", o_e); end
        checks++;
        if (o_ir !== 1'b0) begin errors++; $display("FAIL arst_in_ready got %b exp 0", o_ir); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        drive(1'b0, 1'b1, 1'b1, rand_alu(32'h7));
        cycle();
        drive(1'b0, 1'b0, 1'b1, rand_alu(32'h8));
        cycle();
    endtask

    task automatic test_random();
        entry_t ins;
        logic have;
        reset_all();
        have = 1'b0;
        ins = '0;
        for (int k = 0; k < 400; k++) begin
            if (!have || ($urandom % 8) == 0) begin
                ins = rand_alu(32'(k));
                ins.ard     = AW'($urandom_range(0, 3));
                ins.ars1    = AW'($urandom_range(0, 3));
                ins.ars2    = AW'($urandom_range(0, 3));
                ins.memread = 1'($urandom);
                have = 1'b1;
            end
            drive(($urandom % 16) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0, ins);
            cycle();
            if (m_in_x) have = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        cur = 0;
        drive(1'b0, 1'b0, 1'b0, '0);
        model_clear();
        for (int s = 0; s < 2; s++) begin
            cur = s;
            test_reset();
            test_streaming();
            test_backpressure();
            test_load_use(5'd5, 0, 1, 1);
            test_load_use(5'd0, 0, 0, 0);
            test_load_use(5'd5, 5, 1, 1);
            test_flush();
            test_saturation();
            test_async_reset();
            test_random();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
